// File: rtl/paillier_lfunc.sv
// rtl/paillier_lfunc.sv - Paillier L-function L(u) = (u-1)/n by bit-serial restoring division
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   start          one-cycle request, sampled only in IDLE
//   u              dividend, 2*S limbs of WIDTH bits, limb 0 least significant
//   n              divisor, S limbs of WIDTH bits, limb 0 least significant
//   L              quotient (u-1)/n truncated to S limbs
//   busy           high in LOAD, DIV and FIN
//   done           one-cycle pulse, result and flags valid from this cycle
//   not_divisible  remainder of (u-1)/n is nonzero
//   overflow       quotient has bits set at or above S*WIDTH
//   err_zero       n == 0 or u == 0, L forced to 0
module paillier_lfunc #(
  parameter int WIDTH = 32,
  parameter int S     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2*S-1:0][WIDTH-1:0]  u,
  input  logic [S-1:0][WIDTH-1:0]    n,
  output logic [S-1:0][WIDTH-1:0]    L,
  output logic                       busy,
  output logic                       done,
  output logic                       not_divisible,
  output logic                       overflow,
  output logic                       err_zero
);

  localparam int NW = S * WIDTH;
  localparam int DW = 2 * NW;
  localparam int K  = DW;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, FIN} state_t;

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   d;       // dividend shifting out the top, quotient shifting in the bottom
  logic [NW:0]     r;       // partial remainder, one guard bit above the divisor width
  logic [NW-1:0]   nd;
  logic [CW-1:0]   cnt;

  logic [NW:0]     r_sh;
  logic [NW:0]     r_sub;
  logic            q_bit;
  logic            load_err;

  // One restoring-division step: bring down the next dividend bit, trial-subtract.
  always_comb begin
    r_sh     = {r[NW-1:0], d[DW-1]};
    q_bit    = (r_sh >= {1'b0, nd});
    r_sub    = r_sh - {1'b0, nd};
    // Evaluated in LOAD, where d still holds the undecremented u.
    load_err = (nd == '0) || (d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        state_nx = load_err ? FIN : DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt == CW'(K - 1)) state_nx = FIN;
      end
      FIN: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d             <= '0;
      r             <= '0;
      nd            <= '0;
      cnt           <= '0;
      L             <= '0;
      done          <= 1'b0;
      not_divisible <= 1'b0;
      overflow      <= 1'b0;
      err_zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d             <= u;
            nd            <= n;
            not_divisible <= 1'b0;
            overflow      <= 1'b0;
            err_zero      <= 1'b0;
          end
        end
        LOAD: begin
          d        <= d - DW'(1);
          r        <= '0;
          cnt      <= '0;
          err_zero <= load_err;
        end
        DIV: begin
          d   <= {d[DW-2:0], q_bit};
          r   <= q_bit ? r_sub : r_sh;
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          // Outputs are registered here, so done and the result appear together one cycle after FIN.
          done          <= 1'b1;
          L             <= err_zero ? '0 : d[NW-1:0];
          overflow      <= !err_zero && (|d[DW-1:NW]);
          not_divisible <= !err_zero && (r != '0);
        end
        default: ;
      endcase
    end
  end

endmodule
